// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the Wishbone load/store master
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    // An access that cannot be issued as one bus cycle: illegal size or
    // an address not naturally aligned for its size.
    function automatic logic misaligned(input size_e size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane select, store replication and load extract/extend
module lsu_align
    import lsu_pkg::*;
(
    input  size_e       st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_sel,
    output logic [31:0] st_wdat,
    input  size_e       ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_data,
    output logic [31:0] ld_result
);

    logic [31:0] shifted;

    // Store side: lane selects and write data replicated across all lanes
    always_comb begin
        st_sel  = 4'b0000;
        st_wdat = st_wdata;
        case (st_size)
            SZ_BYTE: begin
                st_sel  = 4'b0001 << st_off;
                st_wdat = {4{st_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_sel  = 4'b0011 << {st_off[1], 1'b0};
                st_wdat = {2{st_wdata[15:0]}};
            end
            SZ_WORD: begin
                st_sel  = 4'b1111;
                st_wdat = st_wdata;
            end
            default: begin
                st_sel  = 4'b0000;
                st_wdat = st_wdata;
            end
        endcase
    end

    // Load side: shift the addressed lane down, truncate, then extend
    always_comb begin
        shifted   = ld_data >> {ld_off, 3'b000};
        ld_result = shifted;
        case (ld_size)
            SZ_BYTE: ld_result = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ld_result = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
            default: ld_result = shifted;
        endcase
    end

endmodule

// File: rtl/wb_lsu_master.sv
// rtl/wb_lsu_master.sv - core load/store to Wishbone classic single-cycle master
module wb_lsu_master
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    // Counter only needs to reach TIMEOUT-1; TIMEOUT of 0 leaves a dummy bit.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_e           state_q;
    state_e           state_d;
    size_e            size_q;
    logic             uns_q;
    logic [1:0]       off_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    size_e       req_size;
    logic        req_bad;
    logic        timed_out;
    logic [3:0]  st_sel;
    logic [31:0] st_wdat;
    logic [31:0] ld_result;

    assign req_size  = size_e'(size_i);
    assign req_bad   = misaligned(req_size, addr_i[1:0]);
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign wb_stb_o  = wb_cyc_o;

    lsu_align u_align (
        .st_size     (req_size),
        .st_off      (addr_i[1:0]),
        .st_wdata    (wdata_i),
        .st_sel      (st_sel),
        .st_wdat     (st_wdat),
        .ld_size     (size_q),
        .ld_off      (off_q),
        .ld_unsigned (uns_q),
        .ld_data     (wb_dat_i),
        .ld_result   (ld_result)
    );

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: bad requests skip the bus; ack beats a same-cycle timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_i) state_d = req_bad ? RESP : BUS;
            BUS:     if (wb_ack_i || timed_out) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: core handshake; RESP is the cycle the core advances
    always_comb begin
        stall_o = 1'b0;
        done_o  = 1'b0;
        err_o   = 1'b0;
        case (state_q)
            IDLE: stall_o = req_i;
            BUS:  stall_o = 1'b1;
            RESP: begin
                done_o = 1'b1;
                err_o  = err_q;
            end
            default: ;
        endcase
    end

    // Bus outputs, latched request, timeout counter and response data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_sel_o <= '0;
            wb_dat_o <= '0;
            rdata_o  <= '0;
            size_q   <= SZ_BYTE;
            uns_q    <= 1'b0;
            off_q    <= 2'b00;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wb_cyc_o <= (state_d == BUS);
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        err_q   <= req_bad;
                        rdata_o <= '0;
                        cnt_q   <= '0;
                        if (!req_bad) begin
                            wb_we_o  <= we_i;
                            wb_adr_o <= {addr_i[31:2], 2'b00};
                            wb_sel_o <= st_sel;
                            wb_dat_o <= st_wdat;
                            size_q   <= req_size;
                            uns_q    <= unsigned_i;
                            off_q    <= addr_i[1:0];
                        end
                    end
                end
                BUS: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (wb_ack_i) begin
                        err_q   <= 1'b0;
                        rdata_o <= wb_we_o ? '0 : ld_result;
                    end else if (timed_out) begin
                        err_q   <= 1'b1;
                        rdata_o <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/wb_lsu_master.md
# wb_lsu_master

Load/store bus master between the core's memory stage and the 32-bit Wishbone data slave. Converts a single core load/store request (byte/half/word, signed/unsigned) into one Wishbone classic cycle with byte selects and lane-replicated write data, then aligns and extends the returned read data. Stalls the core until the access completes, and reports misaligned, illegal-size and timed-out accesses as errors.

## Interface
- TIMEOUT, 16: bus cycles to wait for `wb_ack_i` before aborting; 0 disables the timeout.
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- req_i  in  1  core access request; held stable by the core while `stall_o`=1
- we_i  in  1  1=store, 0=load
- size_i  in  2  0=byte, 1=half, 2=word, 3=illegal
- unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-aligned
- rdata_o  out  32  aligned, extended load data; valid while `done_o`=1
- stall_o  out  1  core must hold the request
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  error qualifier; valid with `done_o`
- wb_cyc_o, wb_stb_o  out  1  Wishbone cycle/strobe; registered, driven together
- wb_we_o  out  1  Wishbone write enable
- wb_adr_o  out  32  Wishbone address: `{addr[31:2],2'b00}`
- wb_sel_o  out  4  byte lane selects
- wb_dat_o  out  32  lane-replicated write data
- wb_dat_i  in  32  slave read data
- wb_ack_i  in  1  slave acknowledge

## Operation
- FSM states: IDLE, BUS, RESP.
- **IDLE**
  - `req_i`=1 with a legal, aligned access: latch we, size, unsigned, `addr[1:0]`, sel and data; go to BUS.
  - `req_i`=1 with size 3, half at `addr[0]`=1, or word at `addr[1:0]`≠0: no bus cycle; go to RESP with the error flag set.
- **BUS**
  - `wb_cyc_o`/`wb_stb_o`=1; address, sel, we and data stay constant.
  - On `wb_ack_i`: capture the extracted load data; drop cyc/stb on the same edge; go to RESP.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without an ack: drop cyc/stb; go to RESP with the error flag set.
- **RESP**
  - `done_o`=1; `err_o`=latched error flag.
  - Always returns to IDLE; never accepts a new request in this cycle.
- **Byte selects**
  - Byte: `4'b0001<<addr[1:0]`.
  - Half: `4'b0011<<{addr[1],1'b0}`.
  - Word: `4'b1111`.
- **Write data**
  - Byte: `{4{wdata[7:0]}}`.
  - Half: `{2{wdata[15:0]}}`.
  - Word: `wdata`.
- **Load data**
  - Extract `wb_dat_i >> (addr[1:0]*8)`, truncate to size, then sign- or zero-extend.
  - Stores and error responses drive `rdata_o`=0.
- `stall_o = (state==IDLE & req_i) | (state==BUS)`; low in RESP, which is the cycle the core advances.
- `wb_dat_i` is ignored when `wb_ack_i`=0. An ack arriving in IDLE or RESP is ignored.

## Timing
- Reset values: state=IDLE; `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `done_o`, `err_o`=0; `wb_sel_o`=0; `wb_adr_o`, `wb_dat_o`, `rdata_o`=0. `stall_o` follows `req_i` once reset has deasserted.
- Against a slave that asserts ack one cycle after seeing stb:
  - request accepted at edge N;
  - cyc/stb high during N+1;
  - ack during N+2;
  - `done_o` during N+3.
- Zero-wait slave (ack in the first BUS cycle): `done_o` 2 cycles after acceptance.
- Error response: `done_o` 1 cycle after acceptance.
- cyc/stb are low in RESP, so a toggling-ack slave never sees back-to-back strobes. Minimum one idle bus cycle between accesses.
- Timeout counter: clears on entry to BUS and increments each BUS cycle. An ack in the same cycle the counter reaches TIMEOUT-1 wins; the response is a normal completion.
- Reset mid-BUS: cyc/stb drop at the reset edge and no `done_o` is produced. The core reissues its request.

## Structure
- `lsu_pkg`: size enum (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL), FSM state enum, `misaligned()` function.
- Sub-module `lsu_align`: combinational block producing sel, write-data replication and load extract/extend. Instantiated once; the FSM, timeout counter and registers stay in `wb_lsu_master`.

## Test plan
- Store byte, addr=0x103, wdata=0x000000AB: `wb_sel_o`=4'b1000, `wb_dat_o`=0xABABABAB, `wb_adr_o`=0x100; `done_o` 3 cycles after acceptance with a one-cycle-ack slave.
- Load half signed, addr=0x22, slave returns 0x8001_1234: `rdata_o`=0xFFFF8001. Same access with unsigned_i=1: `rdata_o`=0x00008001.
- Load word, addr=0x41: no cyc/stb ever asserted; `done_o`=1 and `err_o`=1 one cycle after acceptance; `stall_o` high for exactly 1 cycle.
- TIMEOUT=4, slave never acks: cyc/stb high for exactly 4 cycles, then `done_o`=1, `err_o`=1, `rdata_o`=0.
- Back-to-back store word 0xDEADBEEF @0x10, then load word @0x10 with req_i held high: the two strobes are separated by at least one low cycle; the load returns 0xDEADBEEF.
- rst_i asserted during BUS: the next cycle shows cyc/stb=0, state IDLE and no `done_o`; a following load completes normally.
